// File: rtl/credit_accumulator.sv
// rtl/credit_accumulator.sv - coin credit accumulator with purchase and refund handshakes
// Optional idle-refund timer enabled by defining COIN_TIMEOUT_EN.
module credit_accumulator #(
   parameter int MAX_CREDIT     = 15,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       coin_valid,
   input  logic [1:0] coin_value,
   input  logic       cancel,
   input  logic       req_valid,
   input  logic [3:0] req_price,
   output logic       req_ack,
   output logic       req_ok,
   output logic [3:0] cmoney,
   output logic       refund_valid,
   output logic [3:0] refund_amount,
   input  logic       refund_ready,
   output logic       coin_reject
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CREDIT = 2'd1,
      S_REFUND = 2'd2
   } state_t;

   localparam logic [4:0] MAX_CREDIT_W = 5'(MAX_CREDIT);

   generate
      if (MAX_CREDIT < 1 || MAX_CREDIT > 15 || TIMEOUT_CYCLES < 2) begin : g_param_check
         $error("credit_accumulator: MAX_CREDIT must be 1..15 and TIMEOUT_CYCLES >= 2");
      end
   endgenerate

   state_t     state_q, state_d;
   logic [3:0] credit_q, credit_d;
   logic [3:0] refund_amount_q, refund_amount_d;
   logic       req_ack_q, req_ack_d;
   logic       req_ok_q, req_ok_d;
   logic       coin_reject_q, coin_reject_d;

   logic [4:0] coin_amount;
   logic [4:0] coin_sum;
   logic       coin_fits;
   logic [3:0] remainder;
   logic       timeout;

   always_comb begin
      case (coin_value)
         2'b00:   coin_amount = 5'd1;
         2'b01:   coin_amount = 5'd2;
         2'b10:   coin_amount = 5'd5;
         default: coin_amount = 5'd10;
      endcase
   end

   // Compare in 5 bits so a large coin on high credit cannot wrap.
   assign coin_sum  = {1'b0, credit_q} + coin_amount;
   assign coin_fits = (coin_sum <= MAX_CREDIT_W);
   assign remainder = credit_q - req_price;

`ifdef COIN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] timer_q, timer_d;
   logic          activity;

   assign activity = coin_valid | req_valid | cancel;
   assign timeout  = (state_q == S_CREDIT) && !activity &&
                     (timer_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      timer_d = '0;
      if (state_q == S_CREDIT && !activity && !timeout) begin
         timer_d = timer_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         credit_q        <= '0;
         refund_amount_q <= '0;
         req_ack_q       <= 1'b0;
         req_ok_q        <= 1'b0;
         coin_reject_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         credit_q        <= credit_d;
         refund_amount_q <= refund_amount_d;
         req_ack_q       <= req_ack_d;
         req_ok_q        <= req_ok_d;
         coin_reject_q   <= coin_reject_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      credit_d        = credit_q;
      refund_amount_d = refund_amount_q;
      req_ack_d       = 1'b0;
      req_ok_d        = 1'b0;
      coin_reject_d   = 1'b0;
      case (state_q)
         S_REFUND: begin
            req_ack_d     = req_valid;
            coin_reject_d = coin_valid;
            if (refund_ready) begin
               state_d         = S_IDLE;
               credit_d        = '0;
               refund_amount_d = '0;
            end
         end
         default: begin
            // Cancel outranks a purchase, which outranks a coin; losers are acked-as-failed or returned.
            if ((cancel && state_q == S_CREDIT) || timeout) begin
               state_d         = S_REFUND;
               refund_amount_d = credit_q;
               req_ack_d       = req_valid;
               coin_reject_d   = coin_valid;
            end else if (req_valid) begin
               req_ack_d     = 1'b1;
               coin_reject_d = coin_valid;
               if (credit_q >= req_price) begin
                  req_ok_d = 1'b1;
                  credit_d = remainder;
                  state_d  = (remainder == 4'd0) ? S_IDLE : S_CREDIT;
               end
            end else if (coin_valid) begin
               if (coin_fits) begin
                  credit_d = coin_sum[3:0];
                  state_d  = S_CREDIT;
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_comb begin
      cmoney        = credit_q;
      req_ack       = req_ack_q;
      req_ok        = req_ok_q;
      coin_reject   = coin_reject_q;
      refund_valid  = (state_q == S_REFUND);
      refund_amount = refund_amount_q;
   end

endmodule

// File: tb/tb_credit_accumulator.sv
// tb/tb_credit_accumulator.sv - self-checking bench for credit_accumulator
// Build with or without COIN_TIMEOUT_EN; the DUT is instantiated with TIMEOUT_CYCLES=20.
module tb_credit_accumulator;

   localparam int TO_CYCLES = 20;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       coin_valid = 1'b0;
   logic [1:0] coin_value = 2'b00;
   logic       cancel = 1'b0;
   logic       req_valid = 1'b0;
   logic [3:0] req_price = 4'd0;
   logic       req_ack;
   logic       req_ok;
   logic [3:0] cmoney;
   logic       refund_valid;
   logic [3:0] refund_amount;
   logic       refund_ready = 1'b0;
   logic       coin_reject;

   int checks = 0;
   int errors = 0;
   int coin_vals [4] = '{1, 2, 5, 10};

   credit_accumulator #(.MAX_CREDIT(15), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
      .clock(clock), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
      .cancel(cancel), .req_valid(req_valid), .req_price(req_price), .req_ack(req_ack),
      .req_ok(req_ok), .cmoney(cmoney), .refund_valid(refund_valid),
      .refund_amount(refund_amount), .refund_ready(refund_ready), .coin_reject(coin_reject)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic quiet();
      coin_valid = 1'b0; cancel = 1'b0; req_valid = 1'b0; refund_ready = 1'b0;
   endtask

   task automatic do_reset();
      quiet();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic coin(input int v);
      quiet();
      coin_valid = 1'b1;
      coin_value = (v == 1) ? 2'b00 : (v == 2) ? 2'b01 : (v == 5) ? 2'b10 : 2'b11;
      tick();
      quiet();
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({cmoney, req_ack, req_ok, refund_valid, refund_amount, coin_reject} !== 12'd0) begin
         errors++;
         $display("FAIL reset_outputs: got cmoney=%0d ack=%b ok=%b rv=%b ra=%0d rej=%b, want all 0",
                  cmoney, req_ack, req_ok, refund_valid, refund_amount, coin_reject);
      end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_coins();
      int exp_c [3] = '{5, 10, 12};
      int v [3] = '{5, 5, 2};
      for (int i = 0; i < 3; i++) begin
         coin(v[i]);
         checks++;
         if (cmoney !== 4'(exp_c[i]) || coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL coin_accept_%0d: got cmoney=%0d rej=%b, want %0d rej=0",
                     i, cmoney, coin_reject, exp_c[i]);
         end
      end
   endtask

   task automatic test_overflow();
      coin(10);
      checks++;
      if (coin_reject !== 1'b1 || cmoney !== 4'd12) begin
         errors++;
         $display("FAIL overflow_reject: got rej=%b cmoney=%0d, want rej=1 cmoney=12", coin_reject, cmoney);
      end
      tick();
      checks++;
      if (coin_reject !== 1'b0 || cmoney !== 4'd12) begin
         errors++;
         $display("FAIL overflow_pulse_end: got rej=%b cmoney=%0d, want rej=0 cmoney=12", coin_reject, cmoney);
      end
   endtask

   task automatic test_purchase();
      req_valid = 1'b1; req_price = 4'd7;
      tick();
      req_valid = 1'b0;
      checks++;
      if (req_ack !== 1'b1 || req_ok !== 1'b1 || cmoney !== 4'd5) begin
         errors++;
         $display("FAIL purchase_ok: got ack=%b ok=%b cmoney=%0d, want 1 1 5", req_ack, req_ok, cmoney);
      end
      req_valid = 1'b1; req_price = 4'd9;
      tick();
      req_valid = 1'b0;
      checks++;
      if (req_ack !== 1'b1 || req_ok !== 1'b0 || cmoney !== 4'd5) begin
         errors++;
         $display("FAIL purchase_short: got ack=%b ok=%b cmoney=%0d, want 1 0 5", req_ack, req_ok, cmoney);
      end
      tick();
      checks++;
      if (req_ack !== 1'b0) begin
         errors++;
         $display("FAIL ack_single: got ack=%b, want 0", req_ack);
      end
   endtask

   task automatic test_refund();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            coin_valid = 1'b1; coin_value = 2'b00; req_valid = 1'b1; req_price = 4'd0;
         end
         checks++;
         if (refund_valid !== 1'b1 || refund_amount !== 4'd5 || cmoney !== 4'd5) begin
            errors++;
            $display("FAIL refund_hold_%0d: got rv=%b amt=%0d cmoney=%0d, want 1 5 5",
                     i, refund_valid, refund_amount, cmoney);
         end
         tick();
         quiet();
         if (i == 1) begin
            checks++;
            if (coin_reject !== 1'b1 || req_ack !== 1'b1 || req_ok !== 1'b0) begin
               errors++;
               $display("FAIL refund_blocks: got rej=%b ack=%b ok=%b, want 1 1 0", coin_reject, req_ack, req_ok);
            end
         end
      end
      refund_ready = 1'b1;
      tick();
      refund_ready = 1'b0;
      checks++;
      if (refund_valid !== 1'b0 || cmoney !== 4'd0) begin
         errors++;
         $display("FAIL refund_taken: got rv=%b cmoney=%0d, want 0 0", refund_valid, cmoney);
      end
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      checks++;
      if (refund_valid !== 1'b0 || cmoney !== 4'd0) begin
         errors++;
         $display("FAIL cancel_idle: got rv=%b cmoney=%0d, want 0 0", refund_valid, cmoney);
      end
   endtask

   task automatic test_priority();
      do_reset();
      coin(5); coin(2); coin(1);
      cancel = 1'b1; req_valid = 1'b1; req_price = 4'd3; coin_valid = 1'b1; coin_value = 2'b01;
      tick();
      quiet();
      checks++;
      if (refund_valid !== 1'b1 || refund_amount !== 4'd8 || req_ack !== 1'b1 || req_ok !== 1'b0 ||
          coin_reject !== 1'b1 || cmoney !== 4'd8) begin
         errors++;
         $display("FAIL priority: got rv=%b amt=%0d ack=%b ok=%b rej=%b cmoney=%0d, want 1 8 1 0 1 8",
                  refund_valid, refund_amount, req_ack, req_ok, coin_reject, cmoney);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (refund_valid !== 1'b0 || cmoney !== 4'd0) begin
         errors++;
         $display("FAIL reset_in_refund: got rv=%b cmoney=%0d, want 0 0", refund_valid, cmoney);
      end
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if (refund_valid !== 1'b0) begin
         errors++;
         $display("FAIL refund_discarded: got rv=%b, want 0", refund_valid);
      end
   endtask

   task automatic test_back_to_back();
      int exp_c [3] = '{6, 4, 2};
      do_reset();
      coin(5); coin(2); coin(1);
      req_valid = 1'b1; req_price = 4'd2;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (req_ack !== 1'b1 || req_ok !== 1'b1 || cmoney !== 4'(exp_c[i])) begin
            errors++;
            $display("FAIL back_to_back_%0d: got ack=%b ok=%b cmoney=%0d, want 1 1 %0d",
                     i, req_ack, req_ok, cmoney, exp_c[i]);
         end
      end
      req_valid = 1'b0;
      req_price = 4'd2;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      checks++;
      if (req_ok !== 1'b1 || cmoney !== 4'd0 || refund_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_to_zero: got ok=%b cmoney=%0d rv=%b, want 1 0 0", req_ok, cmoney, refund_valid);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      coin(2);
`ifdef COIN_TIMEOUT_EN
      for (int i = 1; i <= TO_CYCLES; i++) begin
         tick();
         if (i == TO_CYCLES - 1 || i == TO_CYCLES) begin
            checks++;
            if (refund_valid !== (i == TO_CYCLES)) begin
               errors++;
               $display("FAIL timeout_at_%0d: got rv=%b, want %b", i, refund_valid, i == TO_CYCLES);
            end
         end
      end
      checks++;
      if (refund_amount !== 4'd2) begin
         errors++;
         $display("FAIL timeout_amount: got %0d, want 2", refund_amount);
      end
`else
      repeat (3 * TO_CYCLES) tick();
      checks++;
      if (refund_valid !== 1'b0 || cmoney !== 4'd2) begin
         errors++;
         $display("FAIL no_timeout: got rv=%b cmoney=%0d, want 0 2", refund_valid, cmoney);
      end
`endif
   endtask

   task automatic test_random();
      int m_credit = 0, m_amount = 0, m_idle = 0;
      bit m_refund = 0, to_en = 0;
      bit e_ack, e_ok, e_rej, act, in_credit, to;
      int v;
`ifdef COIN_TIMEOUT_EN
      to_en = 1;
`endif
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         coin_valid   = ($urandom_range(0, 9) < 4);
         coin_value   = 2'($urandom_range(0, 3));
         cancel       = ($urandom_range(0, 24) == 0);
         req_valid    = ($urandom_range(0, 9) < 2);
         req_price    = 4'($urandom_range(0, 15));
         refund_ready = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) begin
            coin_valid = 1'b0; cancel = 1'b0; req_valid = 1'b0;
         end
         v = coin_vals[coin_value];
         e_ack = 0; e_ok = 0; e_rej = 0;
         act = coin_valid || cancel || req_valid;
         in_credit = !m_refund && m_credit > 0;
         to = to_en && in_credit && !act && m_idle == TO_CYCLES - 1;
         if (m_refund) begin
            e_ack = req_valid; e_rej = coin_valid;
            if (refund_ready) begin m_refund = 0; m_credit = 0; end
         end else if ((cancel && m_credit > 0) || to) begin
            m_refund = 1; m_amount = m_credit; e_ack = req_valid; e_rej = coin_valid;
         end else if (req_valid) begin
            e_ack = 1; e_rej = coin_valid;
            if (m_credit >= req_price) begin e_ok = 1; m_credit -= req_price; end
         end else if (coin_valid) begin
            if (m_credit + v <= 15) m_credit += v;
            else e_rej = 1;
         end
         m_idle = (in_credit && !act && !to) ? m_idle + 1 : 0;
         tick();
         checks++;
         if (cmoney !== 4'(m_credit) || req_ack !== e_ack || req_ok !== (e_ack & e_ok) ||
             coin_reject !== e_rej || refund_valid !== m_refund ||
             (m_refund && refund_amount !== 4'(m_amount))) begin
            errors++;
            $display("FAIL random_%0d: got c=%0d ack=%b ok=%b rej=%b rv=%b ra=%0d, want c=%0d ack=%b ok=%b rej=%b rv=%b ra=%0d",
                     n, cmoney, req_ack, req_ok, coin_reject, refund_valid, refund_amount,
                     m_credit, e_ack, e_ok, e_rej, m_refund, m_amount);
         end
      end
      quiet();
   endtask

   initial begin
      test_reset();
      test_coins();
      test_overflow();
      test_purchase();
      test_refund();
      test_priority();
      test_back_to_back();
      test_timeout();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/credit_accumulator.md
CREDIT_ACCUMULATOR -- requirements
Module: credit_accumulator

Interface
REQ-001 The block SHALL have parameter MAX_CREDIT, default 15, meaning the maximum credit held (must fit the 4-bit cmoney bus).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning idle clocks with nonzero credit before an automatic refund.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port coin_valid, input, 1 bit: a one-cycle strobe meaning a coin was inserted.
REQ-006 The block SHALL have port coin_value, input, 2 bits: coin code, 00=1, 01=2, 10=5, 11=10.
REQ-007 The block SHALL have port cancel, input, 1 bit: a one-cycle user cancel/refund request.
REQ-008 The block SHALL have port req_valid, input, 1 bit: purchase request from the downstream buying stage.
REQ-009 The block SHALL have port req_price, input, 4 bits: price of the requested item.
REQ-010 The block SHALL have port req_ack, output, 1 bit: a one-cycle purchase response strobe.
REQ-011 The block SHALL have port req_ok, output, 1 bit: purchase granted; valid only while req_ack=1.
REQ-012 The block SHALL have port cmoney, output, 4 bits: current credit, registered.
REQ-013 The block SHALL have port refund_valid, output, 1 bit: refund pending.
REQ-014 The block SHALL have port refund_amount, output, 4 bits: refund value; stable while refund_valid=1.
REQ-015 The block SHALL have port refund_ready, input, 1 bit: the refund is taken when refund_valid and refund_ready are both 1.
REQ-016 The block SHALL have port coin_reject, output, 1 bit: a one-cycle pulse meaning the coin was returned (the redlight source).

Function
REQ-017 The FSM SHALL have states IDLE (credit=0), CREDIT (credit>0) and REFUND.
REQ-018 Coin accept: in IDLE or CREDIT, when coin_valid=1 and credit+value<=MAX_CREDIT (5-bit compare), credit SHALL increase by value on the next edge and the state SHALL go to CREDIT.
REQ-019 Coin overflow: when credit+value>MAX_CREDIT, credit SHALL be unchanged and coin_reject SHALL pulse on the next cycle.
REQ-020 Purchase: when req_valid=1 in IDLE or CREDIT, req_ack SHALL pulse exactly one cycle later.
- If credit>=req_price: req_ok=1 and credit-=req_price.
- Otherwise: req_ok=0 and credit is unchanged.
REQ-021 A request held high for several cycles SHALL be acked once per asserted cycle; the downstream stage drops req_valid after the ack.
REQ-022 After a purchase, a remaining credit of 0 SHALL return the state to IDLE; otherwise the state SHALL stay in CREDIT with the remainder retained.
REQ-023 Cancel in CREDIT SHALL enter REFUND with refund_amount=credit and refund_valid=1 on the next cycle.
REQ-024 Cancel in IDLE SHALL be ignored.
REQ-025 In REFUND, refund_valid and refund_amount SHALL hold until refund_ready=1; on that edge credit:=0, refund_valid:=0 and the state goes to IDLE.
REQ-026 In REFUND, coins SHALL be rejected (coin_reject pulse) and requests SHALL be acked with req_ok=0.
REQ-027 Same-cycle priority SHALL be cancel > req_valid > coin_valid.
- Any coin not processed in that cycle SHALL be rejected with a coin_reject pulse.
- A request arriving with cancel SHALL be acked with req_ok=0.
REQ-028 cmoney SHALL always equal the registered credit and SHALL never exceed MAX_CREDIT.

Reset
REQ-029 On reset, asynchronously: state=IDLE, credit=0, cmoney=0, req_ack=0, req_ok=0, refund_valid=0, refund_amount=0, coin_reject=0, timeout counter=0.
REQ-030 Reset during REFUND SHALL discard the pending refund (no refund_valid after reset).
REQ-031 The first coin SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-032 With macro COIN_TIMEOUT_EN defined, a counter SHALL run in CREDIT.
- It clears on any coin, request or cancel.
- When it reaches TIMEOUT_CYCLES-1 the block enters REFUND with refund_amount=credit, exactly as a cancel.
REQ-033 With COIN_TIMEOUT_EN undefined, no counter SHALL exist and credit SHALL be held indefinitely.

Verification
REQ-034 Reset, then coins 5,5,2 → cmoney 5,10,12 on consecutive cycles; coin_reject stays 0.
REQ-035 With credit=12, insert coin 10 → coin_reject pulses once; cmoney stays 12.
REQ-036 With credit=12, req_price=7 → req_ack=1, req_ok=1 one cycle later; cmoney=5. Then req_price=9 → req_ok=0; cmoney=5.
REQ-037 With credit=5, cancel, refund_ready low for 3 cycles → refund_valid=1 with amount 5 held for 3 cycles; raise refund_ready → IDLE, cmoney=0.
REQ-038 Same cycle cancel + req_valid + coin (credit=8) → refund_amount=8, req_ok=0, coin_reject=1.
REQ-039 With COIN_TIMEOUT_EN defined and TIMEOUT_CYCLES=20: coin 2, then idle for 20 cycles → refund_valid asserts with amount 2. With the macro undefined → no refund.
